score_tracker: RTL and testbench

//  Two-player score accumulator for the Magic Tiles game. Consumes per-player hit/miss

---
 rtl/score_tracker.sv | 90 +++++++++
 tb/tb_score_tracker.sv | 109 ++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// score_tracker: two-player saturating score accumulator and game FSM for Magic Tiles.
// Optional combo bonus is enabled by defining COMBO_BONUS_EN.
module score_tracker #(
   parameter int MAX_SCORE = 99,
   parameter int COMBO_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       end_game,
   input  logic       hit1,
   input  logic       miss1,
   input  logic       hit2,
   input  logic       miss2,
   output logic [7:0] score1,
   output logic [7:0] score2,
   output logic       playing,
   output logic       game_over,
   output logic [1:0] winner
);
   localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2;
   logic [1:0] state, inc1, inc2, win;
   logic [8:0] sum1, sum2;
   logic [7:0] n1, n2;
   logic       done;
`ifdef COMBO_BONUS_EN
   localparam int CW = $clog2(COMBO_LEN) + 1;
   logic [CW-1:0] combo1, combo2, nc1, nc2;
   logic          bonus1, bonus2;
   always_comb begin
      bonus1 = hit1 && !miss1 && (combo1 + 1'b1 == CW'(COMBO_LEN));
      bonus2 = hit2 && !miss2 && (combo2 + 1'b1 == CW'(COMBO_LEN));
      nc1 = (miss1 || bonus1) ? '0 : hit1 ? combo1 + 1'b1 : combo1;
      nc2 = (miss2 || bonus2) ? '0 : hit2 ? combo2 + 1'b1 : combo2;
      inc1 = (hit1 && !miss1) ? (bonus1 ? 2'd2 : 2'd1) : 2'd0;
      inc2 = (hit2 && !miss2) ? (bonus2 ? 2'd2 : 2'd1) : 2'd0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         combo1 <= '0;
         combo2 <= '0;
      end else if (start) begin
         combo1 <= '0;
         combo2 <= '0;
      end else if (state == PLAY) begin
         combo1 <= nc1;
         combo2 <= nc2;
      end
`else
   localparam int combo_len_unused = COMBO_LEN;
   always_comb begin
      inc1 = {1'b0, hit1 && !miss1};
      inc2 = {1'b0, hit2 && !miss2};
   end
`endif
   always_comb begin
      sum1 = {1'b0, score1} + 9'(inc1);
      sum2 = {1'b0, score2} + 9'(inc2);
      n1 = (sum1 > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : sum1[7:0];
      n2 = (sum2 > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : sum2[7:0];
      win = (n1 > n2) ? 2'b01 : (n2 > n1) ? 2'b10 : 2'b11;
      // ceiling check uses the registered score so OVER lands one cycle after reaching it
      done = end_game || score1 == 8'(MAX_SCORE) || score2 == 8'(MAX_SCORE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         score1 <= '0;
         score2 <= '0;
         playing <= 1'b0;
         game_over <= 1'b0;
         winner <= 2'b00;
      end else if (start) begin
         state <= PLAY;
         score1 <= '0;
         score2 <= '0;
         playing <= 1'b1;
         game_over <= 1'b0;
         winner <= 2'b00;
      end else if (state == PLAY) begin
         score1 <= n1;
         score2 <= n2;
         if (done) begin
            state <= OVER;
            playing <= 1'b0;
            game_over <= 1'b1;
            winner <= win;
         end
      end
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed checks of score_tracker (default or COMBO_BONUS_EN build).
module tb_score_tracker;
   logic clk = 0, rst_n = 0;
   logic start = 0, end_game = 0, hit1 = 0, miss1 = 0, hit2 = 0, miss2 = 0;
   logic [7:0] score1, score2;
   logic playing, game_over;
   logic [1:0] winner;
   int n_cmp = 0, n_bad = 0;
`ifdef COMBO_BONUS_EN
   localparam bit BONUS = 1;
`else
   localparam bit BONUS = 0;
`endif
   score_tracker dut (.clk(clk), .rst_n(rst_n), .start(start), .end_game(end_game),
      .hit1(hit1), .miss1(miss1), .hit2(hit2), .miss2(miss2), .score1(score1),
      .score2(score2), .playing(playing), .game_over(game_over), .winner(winner));
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input bit s, input bit e, input bit a, input bit b, input bit c, input bit d);
      @(negedge clk);
      {start, end_game, hit1, miss1, hit2, miss2} = {s, e, a, b, c, d};
      @(posedge clk);
      #1 {start, end_game, hit1, miss1, hit2, miss2} = '0;
   endtask
   function automatic int after(input int n);
      return BONUS ? n + n / 4 : n;
   endfunction
   initial begin
      #2;
      check("rst_s1", score1, 0);
      check("rst_s2", score2, 0);
      check("rst_play", playing, 0);
      check("rst_over", game_over, 0);
      check("rst_win", winner, 0);
      @(negedge clk) rst_n = 1;
      step(0, 0, 1, 0, 1, 0);
      check("idle_hit", score1, 0);
      step(1, 0, 1, 0, 0, 0);
      check("start_play", playing, 1);
      check("start_ignores_hit", score1, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0);
      end
      check("five_hits_s1", score1, after(5));
      check("five_hits_s2", score2, 0);
      step(0, 0, 1, 1, 0, 0);
      check("hit_miss", score1, after(5));
      step(0, 0, 1, 0, 1, 0);
      check("both_hit_s1", score1, after(5) + 1);
      check("both_hit_s2", score2, 1);
      step(0, 1, 0, 0, 1, 0);
      check("end_hit_counted", score2, 2);
      check("end_over", game_over, 1);
      check("end_playing", playing, 0);
      check("end_winner", winner, 1);
      step(0, 0, 1, 0, 0, 0);
      check("over_ignores_hit", score1, after(5) + 1);
      step(1, 0, 0, 0, 0, 0);
      check("restart_s1", score1, 0);
      check("restart_win", winner, 0);
      check("restart_play", playing, 1);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0);
      check("combo_s2", score2, after(7));
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("tie_s1", score1, after(7));
      check("tie_winner", winner, 3);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < (BONUS ? 79 : 98); i++) step(0, 0, 1, 0, 0, 0);
      check("preload_98", score1, 98);
      step(0, 0, 1, 0, 0, 0);
      check("reach_99", score1, 99);
      check("reach_not_over", game_over, 0);
      step(0, 0, 0, 0, 0, 0);
      check("max_over", game_over, 1);
      check("max_winner", winner, 1);
      step(0, 0, 1, 0, 1, 0);
      check("over_hold_s1", score1, 99);
      check("over_hold_s2", score2, 0);
      step(1, 1, 0, 0, 0, 0);
      check("start_beats_end", playing, 1);
      for (int i = 0; i < (BONUS ? 79 : 98); i++) step(0, 0, 1, 0, 1, 0);
      check("both_98", score2, 98);
      step(0, 0, 1, 0, 1, 0);
      check("both_99_s1", score1, 99);
      check("both_99_s2", score2, 99);
      step(0, 0, 0, 0, 0, 0);
      check("both_over", game_over, 1);
      check("both_winner", winner, 3);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      #3 rst_n = 0;
      #1;
      check("midrst_s1", score1, 0);
      check("midrst_play", playing, 0);
      @(negedge clk) rst_n = 1;
      step(0, 0, 1, 0, 0, 0);
      check("midrst_idle", score1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
